// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor with accumulator: DIGIT bits per clock, LSB first,
// N = WIDTH/DIGIT run cycles per operation, valid/ready start and a done pulse.
module serial_add_sub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGIT  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             clear_acc,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             sticky_ovf,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             sub_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             sticky_q;
    logic [WIDTH-1:0] acc_q;
    logic             done_q;

    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_dig;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;
    logic             last_digit;

    always_comb begin
        x_dig    = x_q[int'(cnt_q) * DIGIT +: DIGIT];
        y_dig    = y_q[int'(cnt_q) * DIGIT +: DIGIT];
        {c_dig, s_dig} = {1'b0, x_dig} + {1'b0, y_dig} + {{DIGIT{1'b0}}, carry_q};
        sum_next = sum_q;
        sum_next[int'(cnt_q) * DIGIT +: DIGIT] = s_dig;
        // Y is already inverted for subtraction, so both flavours share one rule
        if (SIGNED) begin
            ovf_next = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum_next[WIDTH-1] != x_q[WIDTH-1]);
        end else begin
            ovf_next = c_dig ^ sub_q;
        end
        last_digit = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            sub_q      <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            sticky_q   <= 1'b0;
            acc_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear_acc) begin
                        acc_q    <= '0;
                        sticky_q <= 1'b0;
                    end
                    if (start_valid) begin
                        // A same-cycle clear takes effect before the accumulator is read
                        x_q     <= op[1] ? (clear_acc ? '0 : acc_q) : a;
                        y_q     <= b ^ {WIDTH{op[0]}};
                        carry_q <= op[0];
                        sub_q   <= op[0];
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= c_dig;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_digit) begin
                        result_q   <= sum_next;
                        overflow_q <= ovf_next;
                        acc_q      <= sum_next;
                        sticky_q   <= sticky_q | ovf_next;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign overflow    = overflow_q;
    assign sticky_ovf  = sticky_q;
    assign acc         = acc_q;

endmodule
